// File: rtl/addbit_pipe.sv
// Pipelined WIDTH-bit adder with carry-in. The operands are split into STAGES
// slices, each slice has one register stage, and the carry ripples between stages.
module addbit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int W = WIDTH / STAGES;

    logic [WIDTH-1:0] ra [STAGES];
    logic [WIDTH-1:0] rb [STAGES];
    logic [WIDTH-1:0] rs [STAGES];
    logic             rc [STAGES];
    logic             rv [STAGES];
    logic             rovf;

    logic [WIDTH-1:0] xa [STAGES];
    logic [WIDTH-1:0] xb [STAGES];
    logic [WIDTH-1:0] xs [STAGES];
    logic             xc [STAGES];
    logic [WIDTH-1:0] ns [STAGES];
    logic             nc [STAGES];
    logic             novf;
    logic             en;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = rv[STAGES-1];
    assign sum       = rs[STAGES-1];
    assign co        = rc[STAGES-1];
    assign ovf       = rovf;

    // Stage k reads the registers of stage k-1. Stage 0 reads the input ports.
    always_comb begin
        logic [W:0] part;
        logic       msb_cin;
        part  = '0;
        xa[0] = a;
        xb[0] = b;
        xs[0] = '0;
        xc[0] = ci;
        for (int unsigned k = 1; k < STAGES; k++) begin
            xa[k] = ra[k-1];
            xb[k] = rb[k-1];
            xs[k] = rs[k-1];
            xc[k] = rc[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            part = {1'b0, xa[k][k*W +: W]} + {1'b0, xb[k][k*W +: W]} + {{W{1'b0}}, xc[k]};
            ns[k] = xs[k];
            ns[k][k*W +: W] = part[W-1:0];
            nc[k] = part[W];
        end
        // Carry into the MSB is recovered from the sum bit and the operand bits.
        msb_cin = ns[STAGES-1][WIDTH-1] ^ xa[STAGES-1][WIDTH-1] ^ xb[STAGES-1][WIDTH-1];
        novf    = (SIGNED != 0) ? (msb_cin ^ nc[STAGES-1]) : nc[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                rv[k] <= 1'b0;
                ra[k] <= '0;
                rb[k] <= '0;
                rs[k] <= '0;
                rc[k] <= 1'b0;
            end
            rovf <= 1'b0;
        end else if (en) begin
            rv[0] <= in_valid;
            for (int unsigned k = 1; k < STAGES; k++) begin
                rv[k] <= rv[k-1];
            end
            for (int unsigned k = 0; k < STAGES; k++) begin
                ra[k] <= xa[k];
                rb[k] <= xb[k];
                rs[k] <= ns[k];
                rc[k] <= nc[k];
            end
            rovf <= novf;
        end
    end
endmodule

// File: tb/tb_addbit_pipe.sv
// Directed self-checking bench for addbit_pipe. It covers the default, signed,
// single-stage and one-bit-per-stage configurations.
module tb_addbit_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // d0: WIDTH=8 STAGES=2 SIGNED=0
    logic       v0, r0, ov0, ordy0, co0, f0, c0;
    logic [7:0] a0, b0, s0;
    // d1: SIGNED=1
    logic       v1, r1, ov1, co1, f1, c1;
    logic [7:0] a1, b1, s1;
    // d2 (STAGES=1) and d3 (STAGES=8) share one set of inputs
    logic       v2, c2, r2, ov2, co2, f2, r3, ov3, co3, f3;
    logic [7:0] a2, b2, s2, s3;

    addbit_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(0)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .a(a0), .b(b0), .ci(c0),
        .out_valid(ov0), .out_ready(ordy0), .sum(s0), .co(co0), .ovf(f0));
    addbit_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1), .ci(c1),
        .out_valid(ov1), .out_ready(1'b1), .sum(s1), .co(co1), .ovf(f1));
    addbit_pipe #(.WIDTH(8), .STAGES(1), .SIGNED(0)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2), .ci(c2),
        .out_valid(ov2), .out_ready(1'b1), .sum(s2), .co(co2), .ovf(f2));
    addbit_pipe #(.WIDTH(8), .STAGES(8), .SIGNED(0)) d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r3), .a(a2), .b(b2), .ci(c2),
        .out_valid(ov3), .out_ready(1'b1), .sum(s3), .co(co3), .ovf(f3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] q[$];
    logic [8:0] e;
    int         got_n;
    int         lat;

    initial begin
        rst_n = 1'b0;
        {v0, a0, b0, c0} = '0;
        ordy0 = 1'b1;
        {v1, a1, b1, c1} = '0;
        {v2, a2, b2, c2} = '0;
        #12;
        check("rst_ov", ov0, 0);
        check("rst_rdy", r0, 1);
        check("rst_sum", {co0, f0, s0}, 0);
        rst_n = 1'b1;

        // Test 1: wrap-around, latency of two edges
        v0 = 1; a0 = 8'hFF; b0 = 8'h01; c0 = 0;
        step();
        v0 = 0;
        check("t1_ov_early", ov0, 0);
        step();
        check("t1_ov", ov0, 1);
        check("t1_res", {co0, f0, s0}, {1'b1, 1'b1, 8'h00});
        step();
        check("t1_drain", ov0, 0);

        // Test 2: signed overflow rules
        v1 = 1; a1 = 8'h7F; b1 = 8'h01; c1 = 0;
        step();
        a1 = 8'hFF;
        step();
        v1 = 0;
        check("t2a_res", {ov1, co1, f1, s1}, {1'b1, 1'b0, 1'b1, 8'h80});
        step();
        check("t2b_res", {ov1, co1, f1, s1}, {1'b1, 1'b1, 1'b0, 8'h00});

        // Test 3: 16-beat stream at full rate
        got_n = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                v0 = 1;
                a0 = 8'(i * 37 + 5);
                b0 = 8'(i * 91 + 3);
                c0 = i[0];
                q.push_back({1'b0, a0} + {1'b0, b0} + {8'd0, c0});
            end else begin
                v0 = 0;
            end
            step();
            check("t3_rdy", r0, 1);
            if (ov0 && q.size() > 0) begin
                e = q.pop_front();
                check("t3_res", {co0, s0}, e);
                got_n++;
            end
        end
        check("t3_count", got_n, 16);

        // Test 4: backpressure holds exactly two beats
        ordy0 = 0;
        v0 = 1; a0 = 8'h0A; b0 = 8'h14; c0 = 0;
        step();
        check("t4_rdy1", r0, 1);
        a0 = 8'h80; b0 = 8'h80; c0 = 1;
        step();
        check("t4_ov", ov0, 1);
        check("t4_rdy0", r0, 0);
        a0 = 8'h33; b0 = 8'h44; c0 = 1;
        step();
        check("t4_hold1", {co0, s0}, 9'h01E);
        step();
        check("t4_hold2", {co0, s0}, 9'h01E);
        check("t4_rdy0b", r0, 0);
        ordy0 = 1;
        #1;
        check("t4_rdy_comb", r0, 1);
        step();
        v0 = 0;
        check("t4_b2", {ov0, co0, s0}, {1'b1, 9'h101});
        step();
        check("t4_b3", {ov0, co0, s0}, {1'b1, 9'h078});
        step();
        check("t4_empty", ov0, 0);

        // Test 5: asynchronous reset mid-stream
        v0 = 1; a0 = 8'h12; b0 = 8'h34; c0 = 0;
        step();
        step();
        check("t5_pre", {ov0, s0}, {1'b1, 8'h46});
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst", {ov0, co0, f0, s0}, 0);
        check("t5_rdy", r0, 1);
        v0 = 0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t5_nostale", ov0, 0);
        end

        // Test 6: latency for STAGES=1 and STAGES=8
        v2 = 1; a2 = 8'hA5; b2 = 8'h5A; c2 = 1;
        step();
        v2 = 0;
        lat = 1;
        check("t6_s1", {ov2, co2, f2, s2}, {1'b1, 1'b1, 1'b1, 8'h00});
        while (!ov3 && lat < 20) begin
            step();
            lat++;
        end
        check("t6_s8_lat", lat, 8);
        check("t6_s8_res", {ov3, co3, s3}, {1'b1, 1'b1, 8'h00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
